sfp_dot_product: RTL and testbench

SFP_DOT_PRODUCT -- requirements
Module: sfp_dot_product

---
 rtl/sfp_dot_product.sv | 185 ++++++++++++++++++
 tb/tb_sfp_dot_product.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_dot_product.sv
// -----------------------------------------------------------------------------
// sfp_dot_product
//
// Signed fixed-point dot product with bias: y = bias + sum(x[i] * w[i]) over
// N_INPUTS beats. Beats arrive on a valid/ready stream. The result is held on
// a valid/ready output port until the consumer takes it.
//
// Number format: two's complement Q(WIDTH-FRAC_BITS).FRAC_BITS for x, w,
// bias and y. Each product is rescaled by an arithmetic right shift, which
// rounds toward minus infinity. The accumulator carries GUARD_BITS extra MSBs
// and wraps modulo 2^(WIDTH+GUARD_BITS).
//
// Build option:
//   SFP_DOT_SATURATE_EN  When defined, out_y is clamped to the signed WIDTH-bit
//                        range and out_sat flags a clamped result. When it is
//                        not defined, out_y is the low WIDTH accumulator bits
//                        (wrap) and out_sat is tied to 0.
//
// Ports:
//   clk        in   single clock; all state changes on its rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   an x/w beat is offered
//   in_ready   out  the block accepts a beat this cycle (ACCUM state)
//   in_x       in   [WIDTH]  signed feature value
//   in_w       in   [WIDTH]  signed weight
//   in_bias    in   [WIDTH]  signed bias, sampled only with beat 0
//   out_valid  out  the result is held and valid (OUT state)
//   out_ready  in   the consumer takes the result
//   out_y      out  [WIDTH]  signed result
//   out_sat    out  the result was clamped (saturation build only)
// -----------------------------------------------------------------------------
module sfp_dot_product #(
  parameter int WIDTH      = 64,
  parameter int FRAC_BITS  = 32,
  parameter int N_INPUTS   = 8,
  parameter int GUARD_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_w,
  input  logic [WIDTH-1:0] in_bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_sat
);

  localparam int ACC_W  = WIDTH + GUARD_BITS;
  localparam int PROD_W = 2 * WIDTH;
  localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_OUT   = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  logic                     accept;
  logic                     last_beat;
  logic signed [PROD_W-1:0] x_ext, w_ext;
  logic signed [PROD_W-1:0] prod_full;
  logic signed [PROD_W-1:0] prod_shift;
  logic signed [ACC_W-1:0]  prod_acc;
  logic signed [ACC_W-1:0]  bias_ext;

  // ---------------------------------------------------------------------------
  // Datapath: full-precision product, rescale, fit to accumulator width
  // ---------------------------------------------------------------------------
  // Operands are widened to the full product width before multiplying, so the
  // multiply is exact. The size casts of signed values sign-extend or truncate
  // as needed, which keeps every WIDTH/GUARD_BITS combination legal.
  assign x_ext      = PROD_W'($signed(in_x));
  assign w_ext      = PROD_W'($signed(in_w));
  assign prod_full  = x_ext * w_ext;
  assign prod_shift = prod_full >>> FRAC_BITS;
  assign prod_acc   = ACC_W'(prod_shift);
  assign bias_ext   = ACC_W'($signed(in_bias));

  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == LAST_BEAT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      S_ACCUM: begin
        in_ready = 1'b1;
        if (accept) begin
          // Beat 0 starts a fresh vector: any previous sum is discarded.
          if (cnt_q == '0) begin
            acc_d = bias_ext + prod_acc;
          end else begin
            acc_d = acc_q + prod_acc;
          end

          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_OUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_OUT: begin
        // The accumulator holds the result. in_ready stays low, so a beat
        // offered during the handoff cycle is not taken.
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_ACCUM;
        end
      end

      default: begin
        state_d = S_ACCUM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result formatting
  // ---------------------------------------------------------------------------
  // out_y is derived from the held accumulator. It is stable for as long as
  // the FSM sits in OUT, and it reads 0 in reset because the accumulator does.
`ifdef SFP_DOT_SATURATE_EN
  logic [GUARD_BITS:0] acc_hi;
  logic                acc_ovf;

  // The value fits in WIDTH signed bits only when the guard bits and the
  // WIDTH-bit sign bit are all copies of one another.
  assign acc_hi  = acc_q[ACC_W-1:WIDTH-1];
  assign acc_ovf = !((&acc_hi) || !(|acc_hi));

  always_comb begin
    out_y   = acc_q[WIDTH-1:0];
    out_sat = 1'b0;
    if (acc_ovf) begin
      out_sat = 1'b1;
      if (acc_q[ACC_W-1]) begin
        out_y = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        out_y = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end
`else
  assign out_y   = acc_q[WIDTH-1:0];
  assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_sfp_dot_product.sv
// -----------------------------------------------------------------------------
// tb_sfp_dot_product
//
// Self-checking bench for sfp_dot_product with WIDTH=64, FRAC_BITS=32,
// N_INPUTS=4, GUARD_BITS=8. Directed vectors cover the basic dot product,
// floor truncation, backpressure, idle gaps, overflow and mid-vector reset.
// Randomized vectors are then compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_sfp_dot_product;

  localparam int WIDTH      = 64;
  localparam int FRAC_BITS  = 32;
  localparam int N_INPUTS   = 4;
  localparam int GUARD_BITS = 8;

  localparam logic signed [71:0] Y_MAX = 72'sh00_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [71:0] Y_MIN = -Y_MAX - 72'sd1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_w;
  logic [WIDTH-1:0] in_bias;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_sat;

  int n_checks;
  int n_errors;

  // Operands of the vector currently being sent.
  logic [63:0] vx [N_INPUTS];
  logic [63:0] vw [N_INPUTS];

  sfp_dot_product #(
    .WIDTH      (WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .N_INPUTS   (N_INPUTS),
    .GUARD_BITS (GUARD_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_bias   (in_bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, exp completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: exact bias + sum of floor-rescaled products in wide integer
  // arithmetic, reduced modulo 2^72 for the accumulator, then either wrapped
  // or clamped to 64 bits depending on the build.
  function automatic void model(input logic [63:0] bias, output logic [63:0] y,
                                output logic sat);
    logic signed [127:0] total;
    logic signed [127:0] p;
    logic signed [71:0]  acc;
    total = 128'($signed(bias));
    for (int i = 0; i < N_INPUTS; i++) begin
      p     = 128'($signed(vx[i])) * 128'($signed(vw[i]));
      total = total + (p >>> FRAC_BITS);
    end
    acc = total[71:0];
`ifdef SFP_DOT_SATURATE_EN
    if (acc > Y_MAX) begin
      y   = 64'h7FFF_FFFF_FFFF_FFFF;
      sat = 1'b1;
    end else if (acc < Y_MIN) begin
      y   = 64'h8000_0000_0000_0000;
      sat = 1'b1;
    end else begin
      y   = acc[63:0];
      sat = 1'b0;
    end
`else
    y   = acc[63:0];
    sat = 1'b0;
`endif
  endfunction

  function automatic logic [63:0] rnd_word();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0) begin
      v = 64'($signed(v[39:0]));
    end
    return v;
  endfunction

  // Offer one beat and wait until it is taken. Called 1 time unit after a
  // rising edge; returns 1 time unit after the accepting edge with in_valid low.
  task automatic send_beat(input logic [63:0] x, input logic [63:0] w,
                           input logic [63:0] bias);
    int waited;
    in_x     = x;
    in_w     = w;
    in_bias  = bias;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("beat_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Send vx/vw with the given bias. Later beats carry a junk bias to show that
  // only beat 0 samples it. Optional idle gap after beat gap_after. The result
  // is checked, held for bp_cycles with in_valid=1 offered, then handed off.
  task automatic run_vector(input string tag, input logic [63:0] bias,
                            input int gap_after, input int gap_len,
                            input int bp_cycles,
                            input logic [63:0] exp_y, input logic exp_sat);
    for (int i = 0; i < N_INPUTS; i++) begin
      send_beat(vx[i], vw[i], (i == 0) ? bias : {$urandom, $urandom});
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clk); #1;
        end
      end
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_y"}, out_y, exp_y);
    check({tag, "_sat"}, 64'(out_sat), 64'(exp_sat));

    for (int c = 0; c < bp_cycles; c++) begin
      in_valid = 1'b1;
      in_x     = {$urandom, $urandom};
      in_w     = {$urandom, $urandom};
      @(posedge clk); #1;
      check({tag, "_bp_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_bp_y"}, out_y, exp_y);
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_handoff_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_handoff_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic load_basic();
    for (int i = 0; i < N_INPUTS; i++) begin
      vx[i] = 64'h0000_0002_0000_0000;  // 2.0
      vw[i] = 64'h0000_0001_8000_0000;  // 1.5
    end
  endtask

  initial begin
    logic [63:0] ey;
    logic        es;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_x      = '0;
    in_w      = '0;
    in_bias   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_y", out_y, 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic vector: 1.0 + 4 * (2.0 * 1.5) = 13.0
    load_basic();
    run_vector("basic", 64'h0000_0001_0000_0000, -1, 0, 0,
               64'h0000_000D_0000_0000, 1'b0);

    // Floor truncation: -1 LSB * 0.5 rounds down to -1 LSB
    for (int i = 0; i < N_INPUTS; i++) begin
      vx[i] = '0;
      vw[i] = '0;
    end
    vx[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    vw[0] = 64'h0000_0000_8000_0000;
    run_vector("neg_trunc", 64'd0, -1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Backpressure: result held 5 cycles with a beat offered, then a vector
    load_basic();
    run_vector("bp", 64'h0000_0001_0000_0000, -1, 0, 5,
               64'h0000_000D_0000_0000, 1'b0);
    run_vector("after_bp", 64'h0000_0001_0000_0000, -1, 0, 0,
               64'h0000_000D_0000_0000, 1'b0);

    // Idle gap of 3 cycles between beats 2 and 3
    run_vector("gap", 64'h0000_0001_0000_0000, 1, 3, 0,
               64'h0000_000D_0000_0000, 1'b0);

    // Overflow of the accumulator range
    for (int i = 0; i < N_INPUTS; i++) begin
      vx[i] = 64'h7FFF_FFFF_0000_0000;
      vw[i] = 64'h7FFF_FFFF_0000_0000;
    end
    model(64'd0, ey, es);
    run_vector("overflow", 64'd0, -1, 0, 0, ey, es);

    // Mid-vector reset after beat 2, then a clean vector
    for (int i = 0; i < N_INPUTS; i++) begin
      vx[i] = 64'h0000_0005_0000_0000;
      vw[i] = 64'h0000_0003_0000_0000;
    end
    send_beat(vx[0], vw[0], 64'h0000_0009_0000_0000);
    send_beat(vx[1], vw[1], 64'h0000_0009_0000_0000);
    rst_n = 1'b0;
    #2;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_y", out_y, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_basic();
    run_vector("post_rst", 64'h0000_0001_0000_0000, -1, 0, 0,
               64'h0000_000D_0000_0000, 1'b0);

    // Randomized vectors against the reference model
    for (int t = 0; t < 40; t++) begin
      logic [63:0] bias;
      for (int i = 0; i < N_INPUTS; i++) begin
        vx[i] = rnd_word();
        vw[i] = rnd_word();
      end
      bias = rnd_word();
      model(bias, ey, es);
      run_vector("rand", bias, $urandom_range(0, N_INPUTS - 1),
                 $urandom_range(0, 2), $urandom_range(0, 3), ey, es);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
